// File: rtl/triple_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | triple_pkg : shared widths, limits and FSM states for triple_accum |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package triple_pkg;

  localparam int TRIPLE_DATA_W = 6;
  localparam int TRIPLE_MAX    = 45;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/triple_acc_add.sv
`default_nettype none
// +------------------------------------------------------------------+
// | triple_acc_add : accumulator adder with carry-out; saturates when  |
// | TRIPLE_ACCUM_SAT_EN is defined, wraps otherwise.  Rev 1.0          |
// +------------------------------------------------------------------+
module triple_acc_add
  import triple_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0]         acc,
  input  logic [TRIPLE_DATA_W-1:0] data,
  output logic [ACC_W-1:0]         sum,
  output logic                     carry
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, acc} + {{(ACC_W + 1 - TRIPLE_DATA_W){1'b0}}, data};
  assign carry  = w_full[ACC_W];

`ifdef TRIPLE_ACCUM_SAT_EN
  // Once clamped, any later addition carries again, so the clamp holds.
  assign sum = carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign sum = w_full[ACC_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/triple_accum.sv
`default_nettype none
// +------------------------------------------------------------------+
// | triple_accum : frames up to N_SAMPLES triple results into a sum    |
// | with sticky overflow; optional macro TRIPLE_ACCUM_SAT_EN. Rev 1.0  |
// +------------------------------------------------------------------+
module triple_accum
  import triple_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TRIPLE_DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic [7:0]               out_count,
  output logic                     out_ovf
);

  localparam logic [7:0] c_last = 8'(N_SAMPLES - 1);

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt, w_sum;
  logic [7:0]       r_count, w_count_nxt;
  logic             r_ovf, w_ovf_nxt, w_carry, w_accept;

  triple_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc   (r_acc),
    .data  (in_data),
    .sum   (w_sum),
    .carry (w_carry)
  );

  assign in_ready  = (r_state != HOLD);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE, ACCUM: begin
        // IDLE holds acc/count/ovf at zero, so both states share the update path.
        if (w_accept) begin
          w_acc_nxt   = w_sum;
          w_count_nxt = r_count + 8'd1;
          w_ovf_nxt   = r_ovf | w_carry;
          w_state_nxt = (r_count == c_last || flush) ? HOLD : ACCUM;
        end else if (flush && r_state == ACCUM) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
